// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: processes one operand bit per clock, LSB first,
// and presents the registered difference and final borrow with a done pulse.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic             InBorr,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Borr,
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] pr;
    logic [WIDTH-1:0] pr_cat;
    logic             br;
    logic [CW-1:0]    cnt;

    logic d_bit;
    logic br_next;
    logic last_bit;
    logic accept;

    // Handshake: start is a level request; it is taken only on an edge where
    // the FSM sits in IDLE and is otherwise ignored. done pulses for one cycle.
    always_comb begin
        d_bit    = a_sr[0] ^ b_sr[0] ^ br;
        br_next  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
        pr_cat   = {d_bit, pr};
        last_bit = (cnt == CW'(WIDTH - 1));
        accept   = (state == IDLE) && start;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The partial result keeps only the bits already produced; the bit being
    // computed this cycle completes it, so the final copy uses pr_cat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr <= '0;
            b_sr <= '0;
            pr   <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            Diff <= '0;
            Borr <= 1'b0;
        end else begin
            busy <= (state_next == SHIFT);
            done <= (state_next == DONE);
            if (accept) begin
                a_sr <= input1;
                b_sr <= input2;
                br   <= InBorr;
                cnt  <= '0;
            end else if (state == SHIFT) begin
                a_sr <= a_sr >> 1;
                b_sr <= b_sr >> 1;
                pr   <= pr_cat[WIDTH-1:1];
                br   <= br_next;
                cnt  <= cnt + CW'(1);
                if (last_bit) begin
                    Diff <= pr_cat;
                    Borr <= br_next;
                end
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed vectors,
// start-while-busy, mid-operation reset and randomized operations.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] input1;
    logic [W-1:0] input2;
    logic         InBorr;
    logic         busy;
    logic         done;
    logic [W-1:0] Diff;
    logic         Borr;
    logic [1:0]   state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    logic [W:0] exp_q[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .input1   (input1),
        .input2   (input2),
        .InBorr   (InBorr),
        .busy     (busy),
        .done     (done),
        .Diff     (Diff),
        .Borr     (Borr),
        .state_dbg(state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: subtraction with borrow on W+1 bits
    function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic bi);
        logic [W:0] r;
        r = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
        return r;
    endfunction

    // Driver: issue one start, scramble inputs after acceptance, observe
    // outputs on falling edges for W+3 cycles.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                         output int lat, output int nbusy, output int ndone,
                         output logic [W-1:0] d, output logic br, output logic ovl,
                         output logic [W:0] held);
        @(negedge clk);
        input1 = a;
        input2 = b;
        InBorr = bi;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        input1 = W'($urandom);
        input2 = W'($urandom);
        InBorr = 1'($urandom);
        lat = 0; nbusy = 0; ndone = 0; d = '0; br = 1'b0; ovl = 1'b0;
        for (int k = 1; k <= W + 3; k++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (busy && done) ovl = 1'b1;
            if (done) begin
                ndone++;
                if (lat == 0) begin
                    lat = k;
                    d   = Diff;
                    br  = Borr;
                end
            end
        end
        held = {Borr, Diff};
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; input1 = '0; input2 = '0; InBorr = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, done, Borr, Diff} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got busy=%b done=%b Borr=%b Diff=%h, want all 0",
                     busy, done, Borr, Diff);
        end
        // start while reset is still low at the edge must be ignored
        start = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL start_in_reset: got busy=%b, want 0", busy);
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_vectors();
        logic [W-1:0] va[4] = '{8'h0F, 8'h05, 8'h00, 8'hFF};
        logic [W-1:0] vb[4] = '{8'h05, 8'h0F, 8'h00, 8'hFF};
        logic         vi[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [W:0]   vx[4] = '{9'h00A, 9'h1F6, 9'h1FF, 9'h000};
        int lat, nb, nd;
        logic [W-1:0] d;
        logic br, ovl;
        logic [W:0] held;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(vx[i]);
            do_op(va[i], vb[i], vi[i], lat, nb, nd, d, br, ovl, held);
            n_cmp++;
            if ({br, d} !== exp_q[0]) begin
                n_err++;
                $display("FAIL vector%0d_result: got %h, want %h", i, {br, d}, exp_q[0]);
            end
            void'(exp_q.pop_front());
            n_cmp++;
            if (nb != W || nd != 1) begin
                n_err++;
                $display("FAIL vector%0d_timing: got busy=%0d done=%0d, want %0d/1", i, nb, nd, W);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int k, nb, nd;
        logic seen;
        logic [W-1:0] d;
        logic br;
        @(negedge clk);
        input1 = 8'h20; input2 = 8'h01; InBorr = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        input1 = 8'h55; input2 = 8'h33; InBorr = 1'b1; start = 1'b1;
        seen = 1'b0;
        k = 0;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            if (done) seen = 1'b1;
        end
        n_cmp++;
        if (!seen || {Borr, Diff} !== 9'h01F) begin
            n_err++;
            $display("FAIL busy_start_result: got seen=%b %h, want 1 01f", seen, {Borr, Diff});
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || {Borr, Diff} !== 9'h01F) begin
            n_err++;
            $display("FAIL busy_start_idle: got busy=%b done=%b %h, want 0 0 01f",
                     busy, done, {Borr, Diff});
        end
        @(posedge clk);
        #1 start = 1'b0;
        nb = 0; nd = 0; d = '0; br = 1'b0;
        for (int j = 1; j <= W + 3; j++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) begin
                nd++;
                d  = Diff;
                br = Borr;
            end
        end
        n_cmp++;
        if (nb != W || nd != 1 || {br, d} !== ref_sub(8'h55, 8'h33, 1'b1)) begin
            n_err++;
            $display("FAIL held_start_op: got busy=%0d done=%0d %h, want %0d 1 %h",
                     nb, nd, {br, d}, W, ref_sub(8'h55, 8'h33, 1'b1));
        end
    endtask

    task automatic test_reset_abort();
        int lat, nb, nd;
        logic [W-1:0] d;
        logic br, ovl, saw_done;
        logic [W:0] held;
        @(negedge clk);
        input1 = 8'h80; input2 = 8'h01; InBorr = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, Borr, Diff} !== '0) begin
            n_err++;
            $display("FAIL async_reset: got busy=%b done=%b Borr=%b Diff=%h, want all 0",
                     busy, done, Borr, Diff);
        end
        saw_done = 1'b0;
        for (int j = 0; j < W + 2; j++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        n_cmp++;
        if (saw_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_no_done: got activity=%b, want 0", saw_done);
        end
        rst_n = 1'b1;
        do_op(8'h03, 8'h01, 1'b0, lat, nb, nd, d, br, ovl, held);
        n_cmp++;
        if ({br, d} !== 9'h002 || nd != 1 || lat != W + 1) begin
            n_err++;
            $display("FAIL after_reset_op: got %h done=%0d lat=%0d, want 002 1 %0d",
                     {br, d}, nd, lat, W + 1);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, d;
        logic bi, br, ovl;
        logic [W:0] held;
        int lat, nb, nd;
        for (int i = 0; i < 1000; i++) begin
            a  = W'($urandom);
            b  = W'($urandom);
            bi = 1'($urandom_range(1, 0));
            exp_q.push_back(ref_sub(a, b, bi));
            do_op(a, b, bi, lat, nb, nd, d, br, ovl, held);
            n_cmp++;
            if ({br, d} !== exp_q[0] || held !== exp_q[0]) begin
                n_err++;
                $display("FAIL random%0d_result: %h-%h-%b got %h held %h, want %h",
                         i, a, b, bi, {br, d}, held, exp_q[0]);
            end
            void'(exp_q.pop_front());
            n_cmp++;
            if (lat != W + 1 || nb != W || nd != 1 || ovl !== 1'b0) begin
                n_err++;
                $display("FAIL random%0d_timing: got lat=%0d busy=%0d done=%0d ovl=%b, want %0d %0d 1 0",
                         i, lat, nb, nd, ovl, W + 1, W);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_start_while_busy();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
